reorder_buffer: RTL and testbench

- Circular in-order reorder buffer for the out-of-order RV32I core.
- Allocates an entry per decoded instruction and broadcasts the rename (register, ROB tag) to the register file.
- Captures results from the common data bus and retires entries in program order, writing committed values back to the register file.
- Detects branch mispredicts at the head and flushes the machine with a redirect PC.

---
 rtl/reorder_buffer.sv | 157 +++++++++++++++
 tb/tb_reorder_buffer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates one entry per issued instruction, captures CDB
// results, retires in program order and flushes the machine on a head branch mispredict.
module reorder_buffer #(
  parameter int unsigned ROB_SIZE_BIT = 3
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,

  input  logic                    issue_valid,
  input  logic [1:0]              issue_type,
  input  logic [4:0]              issue_rd,
  input  logic                    issue_ready,
  input  logic [31:0]             issue_val,
  input  logic                    issue_pred_taken,
  output logic [ROB_SIZE_BIT-1:0] issue_tag,
  output logic                    rob_full,

  input  logic                    wb_valid,
  input  logic [ROB_SIZE_BIT-1:0] wb_tag,
  input  logic [31:0]             wb_val,
  input  logic                    wb_taken,
  input  logic [31:0]             wb_target,

  input  logic [ROB_SIZE_BIT-1:0] qry1_tag,
  input  logic [ROB_SIZE_BIT-1:0] qry2_tag,
  output logic                    qry1_ready,
  output logic                    qry2_ready,
  output logic [31:0]             qry1_val,
  output logic [31:0]             qry2_val,

  output logic                    is_update_dep,
  output logic [4:0]              update_dep_id,
  output logic [ROB_SIZE_BIT-1:0] update_dep,

  output logic                    is_update_val,
  output logic [4:0]              update_val_id,
  output logic [ROB_SIZE_BIT-1:0] update_val_dep,
  output logic [31:0]             update_val,

  output logic                    commit_store,
  output logic                    rob_clear,
  output logic [31:0]             clear_pc
);

  localparam int unsigned ROB_SIZE = 1 << ROB_SIZE_BIT;
  localparam logic [ROB_SIZE_BIT:0] FullCount = (ROB_SIZE_BIT + 1)'(ROB_SIZE);

  localparam logic [1:0] TypeReg    = 2'd0;
  localparam logic [1:0] TypeBranch = 2'd1;
  localparam logic [1:0] TypeStore  = 2'd2;

  typedef logic [ROB_SIZE_BIT-1:0] tag_t;

  logic        busy_q   [ROB_SIZE];
  logic        ready_q  [ROB_SIZE];
  logic [1:0]  type_q   [ROB_SIZE];
  logic [4:0]  rd_q     [ROB_SIZE];
  logic [31:0] val_q    [ROB_SIZE];
  logic        pred_q   [ROB_SIZE];
  logic        taken_q  [ROB_SIZE];
  logic [31:0] target_q [ROB_SIZE];

  tag_t                  head_q, tail_q;
  logic [ROB_SIZE_BIT:0] count_q;

  logic head_fire, mispredict, accept;
  logic qry1_hit, qry2_hit;

  always_comb begin
    head_fire  = rdy_in && busy_q[head_q] && ready_q[head_q];
    mispredict = head_fire && (type_q[head_q] == TypeBranch) &&
                 (taken_q[head_q] != pred_q[head_q]);
    // Fullness uses registered count only; a same-cycle commit never frees a slot for issue.
    rob_full   = (count_q == FullCount);
    accept     = rdy_in && issue_valid && !rob_full && !mispredict;
    issue_tag  = tail_q;

    is_update_dep = accept && (issue_type == TypeReg) && (issue_rd != 5'd0);
    update_dep_id = is_update_dep ? issue_rd : 5'd0;
    update_dep    = is_update_dep ? tail_q : '0;

    is_update_val  = head_fire && (type_q[head_q] == TypeReg) && (rd_q[head_q] != 5'd0);
    update_val_id  = is_update_val ? rd_q[head_q] : 5'd0;
    update_val_dep = is_update_val ? head_q : '0;
    update_val     = is_update_val ? val_q[head_q] : 32'd0;

    commit_store = head_fire && (type_q[head_q] == TypeStore);
    rob_clear    = mispredict;
    clear_pc     = mispredict ? target_q[head_q] : 32'd0;
  end

  // Operand lookup forwards a same-cycle CDB broadcast ahead of stored values.
  always_comb begin
    qry1_hit   = wb_valid && (wb_tag == qry1_tag);
    qry2_hit   = wb_valid && (wb_tag == qry2_tag);
    qry1_ready = (busy_q[qry1_tag] && ready_q[qry1_tag]) || qry1_hit;
    qry2_ready = (busy_q[qry2_tag] && ready_q[qry2_tag]) || qry2_hit;
    qry1_val   = qry1_hit ? wb_val : (qry1_ready ? val_q[qry1_tag] : 32'd0);
    qry2_val   = qry2_hit ? wb_val : (qry2_ready ? val_q[qry2_tag] : 32'd0);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        busy_q[i]   <= 1'b0;
        ready_q[i]  <= 1'b0;
        type_q[i]   <= 2'd0;
        rd_q[i]     <= 5'd0;
        val_q[i]    <= 32'd0;
        pred_q[i]   <= 1'b0;
        taken_q[i]  <= 1'b0;
        target_q[i] <= 32'd0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rdy_in) begin
      if (mispredict) begin
        for (int i = 0; i < ROB_SIZE; i++) begin
          busy_q[i] <= 1'b0;
        end
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (wb_valid && busy_q[wb_tag]) begin
          ready_q[wb_tag]  <= 1'b1;
          val_q[wb_tag]    <= wb_val;
          taken_q[wb_tag]  <= wb_taken;
          target_q[wb_tag] <= wb_target;
        end
        if (head_fire) begin
          busy_q[head_q] <= 1'b0;
          head_q         <= head_q + tag_t'(1);
        end
        // Tail is never busy when accepting, so this cannot collide with the writeback above.
        if (accept) begin
          busy_q[tail_q]  <= 1'b1;
          ready_q[tail_q] <= issue_ready;
          type_q[tail_q]  <= issue_type;
          rd_q[tail_q]    <= issue_rd;
          val_q[tail_q]   <= issue_val;
          pred_q[tail_q]  <= issue_pred_taken;
          taken_q[tail_q] <= issue_pred_taken;
          tail_q          <= tail_q + tag_t'(1);
        end
        unique case ({accept, head_fire})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus random traffic, all checked every cycle
// against a program-order queue model of the buffer.
module tb_reorder_buffer;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        issue_valid, issue_ready, issue_pred_taken;
  logic [1:0]  issue_type;
  logic [4:0]  issue_rd;
  logic [31:0] issue_val;
  logic [2:0]  issue_tag;
  logic        rob_full;
  logic        wb_valid, wb_taken;
  logic [2:0]  wb_tag;
  logic [31:0] wb_val, wb_target;
  logic [2:0]  qry1_tag, qry2_tag;
  logic        qry1_ready, qry2_ready;
  logic [31:0] qry1_val, qry2_val;
  logic        is_update_dep, is_update_val, commit_store, rob_clear;
  logic [4:0]  update_dep_id, update_val_id;
  logic [2:0]  update_dep, update_val_dep;
  logic [31:0] update_val, clear_pc;

  always #5 clk_in = ~clk_in;

  reorder_buffer #(.ROB_SIZE_BIT(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_ready(issue_ready), .issue_val(issue_val), .issue_pred_taken(issue_pred_taken),
    .issue_tag(issue_tag), .rob_full(rob_full),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val), .wb_taken(wb_taken),
    .wb_target(wb_target),
    .qry1_tag(qry1_tag), .qry2_tag(qry2_tag), .qry1_ready(qry1_ready),
    .qry2_ready(qry2_ready), .qry1_val(qry1_val), .qry2_val(qry2_val),
    .is_update_dep(is_update_dep), .update_dep_id(update_dep_id), .update_dep(update_dep),
    .is_update_val(is_update_val), .update_val_id(update_val_id),
    .update_val_dep(update_val_dep), .update_val(update_val),
    .commit_store(commit_store), .rob_clear(rob_clear), .clear_pc(clear_pc)
  );

  typedef struct {
    int          tag;
    int          typ;
    int          rd;
    bit          rdy;
    logic [31:0] val;
    bit          pred;
    bit          taken;
    logic [31:0] target;
  } ent_t;

  ent_t q[$];      // in-flight instructions, oldest first
  int   alloc;     // tag the next issued instruction will receive
  int   total = 0;
  int   bad   = 0;

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic qry_model(input int t, output bit r, output logic [31:0] v);
    r = 1'b0;
    v = 32'd0;
    foreach (q[i]) if (q[i].tag == t && q[i].rdy) begin r = 1'b1; v = q[i].val; end
    if (wb_valid && int'(wb_tag) == t) begin r = 1'b1; v = wb_val; end
  endtask

  task automatic idle();
    rdy_in = 1'b1;
    issue_valid = 1'b0; issue_type = 2'd0; issue_rd = 5'd0; issue_ready = 1'b0;
    issue_val = 32'd0; issue_pred_taken = 1'b0;
    wb_valid = 1'b0; wb_tag = 3'd0; wb_val = 32'd0; wb_taken = 1'b0; wb_target = 32'd0;
    qry1_tag = 3'd0; qry2_tag = 3'd0;
  endtask

  task automatic set_issue(input int typ, input int rd, input bit rdy, input logic [31:0] v,
                           input bit pred);
    issue_valid = 1'b1; issue_type = 2'(typ); issue_rd = 5'(rd); issue_ready = rdy;
    issue_val = v; issue_pred_taken = pred;
  endtask

  task automatic set_wb(input int tag, input logic [31:0] v, input bit tk, input logic [31:0] tg);
    wb_valid = 1'b1; wb_tag = 3'(tag); wb_val = v; wb_taken = tk; wb_target = tg;
  endtask

  // Check all outputs mid-cycle against the model, then advance the model across the edge.
  task automatic cycle();
    bit full, commit, mis, acc, exp_dep, exp_uv, r;
    logic [31:0] v;
    ent_t e;
    @(negedge clk_in);
    #1;
    if (rst_in) begin q.delete(); alloc = 0; end
    full   = (q.size() == 8);
    commit = rdy_in && !rst_in && q.size() > 0 && q[0].rdy;
    mis    = commit && q[0].typ == 1 && q[0].taken != q[0].pred;
    acc    = rdy_in && !rst_in && issue_valid && !full && !mis;
    check_eq("issue_tag", issue_tag, alloc);
    check_eq("rob_full", rob_full, full);
    exp_dep = acc && issue_type == 2'd0 && issue_rd != 5'd0;
    check_eq("is_update_dep", is_update_dep, exp_dep);
    if (exp_dep) begin
      check_eq("update_dep_id", update_dep_id, issue_rd);
      check_eq("update_dep", update_dep, alloc);
    end
    exp_uv = commit && q[0].typ == 0 && q[0].rd != 0;
    check_eq("is_update_val", is_update_val, exp_uv);
    if (exp_uv) begin
      check_eq("update_val_id", update_val_id, q[0].rd);
      check_eq("update_val_dep", update_val_dep, q[0].tag);
      check_eq("update_val", update_val, q[0].val);
    end
    check_eq("commit_store", commit_store, commit && q[0].typ == 2);
    check_eq("rob_clear", rob_clear, mis);
    if (mis) check_eq("clear_pc", clear_pc, q[0].target);
    if (rst_in) check_eq("clear_pc_rst", clear_pc, 32'd0);
    qry_model(int'(qry1_tag), r, v);
    check_eq("qry1_ready", qry1_ready, r);
    if (r) check_eq("qry1_val", qry1_val, v);
    qry_model(int'(qry2_tag), r, v);
    check_eq("qry2_ready", qry2_ready, r);
    if (r) check_eq("qry2_val", qry2_val, v);
    @(posedge clk_in);
    if (!rst_in && rdy_in) begin
      if (mis) begin
        q.delete();
        alloc = 0;
      end else begin
        if (wb_valid) begin
          foreach (q[i]) if (q[i].tag == int'(wb_tag)) begin
            e = q[i];
            e.rdy = 1'b1; e.val = wb_val; e.taken = wb_taken; e.target = wb_target;
            q[i] = e;
          end
        end
        if (commit) void'(q.pop_front());
        if (acc) begin
          e.tag = alloc; e.typ = int'(issue_type); e.rd = int'(issue_rd);
          e.rdy = issue_ready; e.val = issue_val; e.pred = issue_pred_taken;
          e.taken = issue_pred_taken; e.target = 32'd0;
          q.push_back(e);
          alloc = (alloc + 1) % 8;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_in = 1'b1;
    cycle();
    cycle();
    rst_in = 1'b0;
    cycle();
  endtask

  // Complete the oldest pending entry each cycle until the buffer is empty (bounded).
  task automatic drain();
    for (int n = 0; n < 40 && q.size() > 0; n++) begin
      idle();
      foreach (q[i]) if (!q[i].rdy && !wb_valid) set_wb(q[i].tag, $urandom, q[i].pred, 32'h0);
      cycle();
    end
    check_eq("drained", q.size(), 0);
  endtask

  initial begin
    alloc = 0;
    rst_in = 1'b1;
    idle();

    // 1: single reg-write issue, writeback, commit
    do_reset();
    set_issue(0, 5, 0, 0, 0); cycle();
    idle(); set_wb(0, 32'h2A, 0, 0); cycle();
    idle(); cycle(); cycle();

    // 2: fill to capacity, ninth issue rejected, one commit frees a slot
    do_reset();
    for (int i = 0; i < 9; i++) begin set_issue(0, i + 1, 0, 32'h0, 0); cycle(); end
    idle(); set_wb(0, 32'h77, 0, 0); cycle();
    idle(); cycle(); cycle();
    drain();

    // 3: out-of-order writeback, in-order retirement
    do_reset();
    for (int i = 0; i < 3; i++) begin set_issue(0, i + 1, 0, 32'h0, 0); cycle(); end
    for (int i = 2; i >= 0; i--) begin idle(); set_wb(i, 32'h100 + i, 0, 0); cycle(); end
    idle(); for (int i = 0; i < 4; i++) cycle();

    // 4: head branch mispredict flushes younger work
    do_reset();
    set_issue(1, 0, 0, 0, 0); cycle();
    set_issue(0, 7, 0, 0, 0); cycle();
    idle(); set_wb(1, 32'h11, 0, 0); cycle();
    idle(); set_wb(0, 32'h0, 1, 32'h1000); cycle();
    idle(); cycle();
    set_issue(0, 3, 0, 0, 0); cycle();
    drain();

    // 5: operand query forwarding from the CDB, then from storage
    do_reset();
    for (int i = 0; i < 4; i++) begin set_issue(0, i + 1, 0, 32'h0, 0); cycle(); end
    idle(); qry1_tag = 3'd3; qry2_tag = 3'd2; set_wb(3, 32'h55, 0, 0); cycle();
    idle(); qry1_tag = 3'd3; qry2_tag = 3'd2; cycle();
    drain();

    // 6: streaming rd=0 / store pairs with a rdy_in freeze in the middle
    do_reset();
    for (int i = 0; i < 20; i++) begin
      idle();
      if (i % 2 == 0) set_issue(0, 0, 1, 32'h0, 0);
      else            set_issue(2, 0, 1, 32'h0, 0);
      if (i >= 10 && i < 13) rdy_in = 1'b0;
      cycle();
    end
    idle(); cycle(); cycle();

    // Random traffic with occasional stalls and mid-flight resets
    for (int n = 0; n < 1500; n++) begin
      idle();
      if ($urandom_range(299) == 0) begin
        rst_in = 1'b1; cycle(); rst_in = 1'b0; continue;
      end
      rdy_in = ($urandom_range(9) != 0);
      if ($urandom_range(1) == 1) begin
        int t;
        t = $urandom_range(3);
        set_issue(t, ($urandom_range(3) == 0) ? 0 : $urandom_range(31),
                  (t != 1) && ($urandom_range(2) == 0), $urandom, $urandom_range(1));
      end
      if (q.size() > 0 && $urandom_range(1) == 1) begin
        int k;
        k = $urandom_range(q.size() - 1);
        set_wb(q[k].tag, $urandom, ($urandom_range(3) == 0) ? !q[k].pred : q[k].pred, $urandom);
      end else if ($urandom_range(3) == 0) begin
        set_wb($urandom_range(7), $urandom, $urandom_range(1), $urandom);
      end
      qry1_tag = 3'($urandom_range(7));
      qry2_tag = 3'($urandom_range(7));
      cycle();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
